dmem_bridge: RTL and testbench

Sequential bridge between the MEM-stage byte-lane/alignment logic and the data memory bus. It captures one load or store per instruction, drives a request/address-ok/data-ok bus handshake, and stalls the pipeline until the access completes. Captured read data is held stable for the downstream load-extraction logic until the pipeline advances.

---
 rtl/dmem_bridge_pkg.sv | 31 +++
 rtl/dmem_bridge_if.sv | 23 ++
 rtl/dmem_bridge_addr_map.sv | 9 +
 rtl/dmem_bridge.sv | 131 +++++++++++++
 tb/tb_dmem_bridge.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge and its address map.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  SIZE_B       = 2'd0;
  localparam logic [1:0]  SIZE_H       = 2'd1;
  localparam logic [1:0]  SIZE_W       = 2'd2;

  localparam logic [1:0]  KSEG_TAG     = 2'b10;
  localparam logic [31:0] KSEG_MASK    = 32'h1FFF_FFFF;
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // kseg0/kseg1 both fold onto the low 512 MB of physical space
  function automatic logic [31:0] kseg_xlate(input logic [31:0] va);
    return (va[31:30] == KSEG_TAG) ? (va & KSEG_MASK) : va;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/address-ok/data-ok data bus between the bridge (master) and memory (slave).
interface dmem_bridge_if;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, bus_err,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, bus_err,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge_addr_map.sv
// Combinational virtual-to-physical translation; shared with the fetch bridge.
module dmem_bridge_addr_map
  import dmem_bridge_pkg::*;
(
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);
  assign paddr = kseg_xlate(vaddr);
endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage load/store bridge: one outstanding bus access, stalls until done.
// Optional DMEM_TIMEOUT_EN aborts a hung access after TIMEOUT_CYCLES with bus_err.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_en,
  input  logic [3:0]   mem_wen,
  input  logic [1:0]   mem_size,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic         addr_exc,
  input  logic         flush,
  input  logic         ext_stall,
  output logic         stall,
  output logic [31:0]  mem_rdata,
  dmem_bridge_if.master bus
);

  state_t state, state_n;
  req_t   req_q;
  logic   wr_q;
  logic   cancel_q;
  logic   start;
  logic   to_hit;
  logic [31:0] paddr;

  assign start = mem_en & ~addr_exc & ~flush;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
  logic       err_q;

  // counter value TO_LAST marks the TIMEOUT_CYCLES-th busy cycle
  assign to_hit = ((state == ST_REQ) || (state == ST_WAIT)) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_hit;
      if (state == ST_IDLE && start)
        to_cnt <= '0;
      else if (state == ST_REQ || state == ST_WAIT)
        to_cnt <= to_cnt + 8'd1;
    end
  end

  assign bus.bus_err = err_q;
`else
  assign to_hit      = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        stall = start;
        if (start) state_n = ST_REQ;
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus.bus_addr_ok) state_n = ST_WAIT;
        else if (flush)      state_n = ST_IDLE;
      end
      ST_WAIT: begin
        stall = ~cancel_q;
        if (bus.bus_data_ok) state_n = cancel_q ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (flush || !ext_stall) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (to_hit) state_n = ST_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      wr_q      <= 1'b0;
      cancel_q  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        req_q <= '{wen: mem_wen, size: mem_size, addr: mem_addr, wdata: mem_wdata};
        wr_q  <= |mem_wen;
      end

      // cancel marks a response that belongs to a flushed instruction
      if (to_hit)
        cancel_q <= 1'b0;
      else if (state == ST_REQ && bus.bus_addr_ok && flush)
        cancel_q <= 1'b1;
      else if (state == ST_WAIT) begin
        if (bus.bus_data_ok) cancel_q <= 1'b0;
        else if (flush)      cancel_q <= 1'b1;
      end

      if (to_hit)
        mem_rdata <= TIMEOUT_FILL;
      else if (state == ST_WAIT && bus.bus_data_ok && !cancel_q && !wr_q)
        mem_rdata <= bus.bus_rdata;
    end
  end

  dmem_bridge_addr_map u_addr_map (
    .vaddr (req_q.addr),
    .paddr (paddr)
  );

  assign bus.bus_req   = (state == ST_REQ);
  assign bus.bus_wr    = wr_q;
  assign bus.bus_size  = req_q.size;
  assign bus.bus_wstrb = req_q.wen;
  assign bus.bus_addr  = paddr;
  assign bus.bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: load, store, flush cases, DONE hold, async reset.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, addr_exc, flush, ext_stall;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall;
  logic [31:0] mem_rdata;
  int          total = 0;
  int          bad   = 0;

  dmem_bridge_if bus ();

  dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .addr_exc  (addr_exc),
    .flush     (flush),
    .ext_stall (ext_stall),
    .stall     (stall),
    .mem_rdata (mem_rdata),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] wen, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_en = 1'b1; mem_wen = wen; mem_size = sz; mem_addr = a; mem_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    mem_en = 0; mem_wen = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
    addr_exc = 0; flush = 0; ext_stall = 0;
    bus.bus_addr_ok = 0; bus.bus_data_ok = 0; bus.bus_rdata = 0;
    tick(); tick();
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus.bus_req, 0);
    chk("rst_wr", bus.bus_wr, 0);
    chk("rst_addr", bus.bus_addr, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_err", bus.bus_err, 0);
    rst = 1'b0;
    tick();

    // load word through kseg0, stall spans IDLE, REQ, WAIT, WAIT
    issue(4'b0000, SIZE_W, 32'h8000_0010, 32'h0);
    #1 chk("ld_idle_stall", stall, 1);
    tick(); mem_en = 0; bus.bus_addr_ok = 1;
    #1 chk("ld_req", bus.bus_req, 1);
    chk("ld_paddr", bus.bus_addr, 32'h0000_0010);
    chk("ld_wr", bus.bus_wr, 0);
    chk("ld_size", bus.bus_size, SIZE_W);
    chk("ld_req_stall", stall, 1);
    tick(); bus.bus_addr_ok = 0;
    #1 chk("ld_wait_req", bus.bus_req, 0);
    chk("ld_wait_stall", stall, 1);
    tick(); bus.bus_data_ok = 1; bus.bus_rdata = 32'h1234_5678;
    #1 chk("ld_wait2_stall", stall, 1);
    tick(); bus.bus_data_ok = 0; bus.bus_rdata = 0;
    #1 chk("ld_done_stall", stall, 0);
    chk("ld_done_rdata", mem_rdata, 32'h1234_5678);
    tick();

    // store byte through kseg1
    issue(4'b0100, SIZE_B, 32'hA000_0002, 32'h00AB_0000);
    #1 chk("st_idle_stall", stall, 1);
    tick(); mem_en = 0; bus.bus_addr_ok = 1;
    #1 chk("st_req", bus.bus_req, 1);
    chk("st_wr", bus.bus_wr, 1);
    chk("st_wstrb", bus.bus_wstrb, 4'b0100);
    chk("st_paddr", bus.bus_addr, 32'h0000_0002);
    chk("st_wdata", bus.bus_wdata, 32'h00AB_0000);
    tick(); bus.bus_addr_ok = 0; bus.bus_data_ok = 1; bus.bus_rdata = 32'h5555_5555;
    tick(); bus.bus_data_ok = 0; bus.bus_rdata = 0;
    #1 chk("st_done_stall", stall, 0);
    chk("st_rdata_kept", mem_rdata, 32'h1234_5678);
    tick();

    // flush in REQ before addr_ok
    issue(4'b0000, SIZE_W, 32'h0000_1000, 32'h0);
    tick(); mem_en = 0; flush = 1;
    #1 chk("fl_req", bus.bus_req, 1);
    chk("fl_paddr", bus.bus_addr, 32'h0000_1000);
    tick(); flush = 0;
    #1 chk("fl_req_drop", bus.bus_req, 0);
    chk("fl_stall", stall, 0);
    tick();
    #1 chk("fl_rdata", mem_rdata, 32'h1234_5678);

    // flush with addr_ok: response arrives later and is discarded
    issue(4'b0000, SIZE_W, 32'h8000_0020, 32'h0);
    tick(); mem_en = 0; flush = 1; bus.bus_addr_ok = 1;
    tick(); flush = 0; bus.bus_addr_ok = 0;
    #1 chk("cx_wait_stall", stall, 0);
    chk("cx_wait_req", bus.bus_req, 0);
    tick();
    tick(); bus.bus_data_ok = 1; bus.bus_rdata = 32'hFFFF_FFFF;
    #1 chk("cx_resp_stall", stall, 0);
    tick(); bus.bus_data_ok = 0; bus.bus_rdata = 0;
    #1 chk("cx_rdata", mem_rdata, 32'h1234_5678);
    chk("cx_req", bus.bus_req, 0);

    // back in IDLE: a new start stalls at once
    issue(4'b0000, SIZE_W, 32'h0000_0040, 32'h0);
    #1 chk("cx_idle_stall", stall, 1);
    tick(); mem_en = 0; bus.bus_addr_ok = 1;
    tick(); bus.bus_addr_ok = 0; bus.bus_data_ok = 1; bus.bus_rdata = 32'hCAFE_F00D;
    ext_stall = 1;
    tick(); bus.bus_data_ok = 0; bus.bus_rdata = 0;
    issue(4'b0000, SIZE_W, 32'h0000_0080, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("hold_rdata", mem_rdata, 32'hCAFE_F00D);
      chk("hold_req", bus.bus_req, 0);
      chk("hold_stall", stall, 0);
      tick();
    end
    ext_stall = 0;
    tick();
    #1 chk("next_idle_stall", stall, 1);
    chk("next_idle_req", bus.bus_req, 0);
    tick(); mem_en = 0; bus.bus_addr_ok = 1;
    #1 chk("next_req", bus.bus_req, 1);
    chk("next_paddr", bus.bus_addr, 32'h0000_0080);
    tick(); bus.bus_addr_ok = 0;
    #1 chk("mid_wait_stall", stall, 1);

    // async reset in the middle of WAIT
    #2 rst = 1'b1;
    #1 chk("arst_stall", stall, 0);
    chk("arst_req", bus.bus_req, 0);
    chk("arst_addr", bus.bus_addr, 0);
    chk("arst_wr", bus.bus_wr, 0);
    chk("arst_wstrb", bus.bus_wstrb, 0);
    chk("arst_wdata", bus.bus_wdata, 0);
    chk("arst_rdata", mem_rdata, 0);
    chk("arst_err", bus.bus_err, 0);
    tick(); rst = 1'b0;
    tick();

`ifdef DMEM_TIMEOUT_EN
    begin
      int          pulses;
      logic [31:0] err_rdata;
      pulses = 0; err_rdata = 0;
      issue(4'b0000, SIZE_W, 32'h0000_0100, 32'h0);
      tick(); mem_en = 0; bus.bus_addr_ok = 1;
      tick(); bus.bus_addr_ok = 0;
      for (int i = 0; i < 8; i++) begin
        #1 if (bus.bus_err) begin pulses++; err_rdata = mem_rdata; end
        tick();
      end
      chk("to_pulses", pulses, 1);
      chk("to_rdata", err_rdata, 32'hDEAD_BEEF);
      chk("to_stall", stall, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
